tx_fifo: RTL and testbench

TX_FIFO -- requirements
Module: tx_fifo

---
 rtl/tx_fifo.sv | 147 ++++++++++++++
 tb/tb_tx_fifo.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_fifo.sv
// Transmit byte FIFO with launch/wait sequencer for a serial transmitter.
// The controller pushes bytes into a circular buffer. A three-state FSM
// launches one byte at a time and then waits for tx_finish or a timeout.
// fifo_interrupt merges three events: low-watermark refill, done, and timeout.
//
//   state  | meaning
//   IDLE   | waiting for a queued byte and an idle transmitter
//   LAUNCH | pop head byte into tx_data, tx_start follows next cycle
//   WAIT   | byte in flight, waiting for tx_finish or timeout
module tx_fifo #(
  parameter int          DEPTH   = 8,
  parameter int          THRESH  = 2,
  parameter logic [20:0] TIMEOUT = 21'd100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ctrl_tx_data,
  input  logic       ctrl_tx_valid,
  output logic       tx_ctrl_ack,
  output logic       tx_ctrl_full,
  output logic [3:0] fifo_count,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  input  logic       tx_finish,
  output logic       fifo_interrupt
);

  localparam int          PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [3:0]  DEPTH_C    = 4'(DEPTH);
  localparam logic [3:0]  REFILL_C   = 4'(THRESH + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]    count_q, count_d;
  logic [20:0]   tmo_q, tmo_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          ack_q, ack_d;
  logic          irq_q, irq_d;
  logic [7:0]    mem_q [DEPTH];

  logic push;
  logic pop;
  logic done_evt;
  logic tmo_evt;
  logic refill_evt;

  assign tx_ctrl_full   = (count_q == DEPTH_C);
  assign fifo_count     = count_q;
  assign tx_start       = tx_start_q;
  assign tx_data        = tx_data_q;
  assign tx_ctrl_ack    = ack_q;
  assign fifo_interrupt = irq_q;

  // Full is judged on the pre-pop count, so a same-cycle pop never frees room
  assign push = ctrl_tx_valid && (count_q != DEPTH_C);

  // Sequencer next-state, pop decision and timeout counter
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    tmo_d    = 21'd0;
    done_evt = 1'b0;
    tmo_evt  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((count_q != 4'd0) && !tx_busy) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        pop     = (count_q != 4'd0);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_finish) begin
          state_d  = ST_IDLE;
          done_evt = (count_q == 4'd0);
        end else if (21'(tmo_q + 21'd1) == TIMEOUT) begin
          state_d = ST_IDLE;
          tmo_evt = 1'b1;
        end else begin
          tmo_d = 21'(tmo_q + 21'd1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pointer, occupancy, output register and interrupt next values
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : PW'(wr_ptr_q + 1'b1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : PW'(rd_ptr_q + 1'b1);
    case ({push, pop})
      2'b10:   count_d = 4'(count_q + 4'd1);
      2'b01:   count_d = 4'(count_q - 4'd1);
      default: count_d = count_q;
    endcase
    refill_evt = pop && !push && (count_q == REFILL_C);
    tx_start_d = pop;
    tx_data_d  = pop ? mem_q[rd_ptr_q] : tx_data_q;
    ack_d      = push;
    // Coincident events collapse into one pulse; back-to-back pulses are suppressed
    irq_d      = (refill_evt || done_evt || tmo_evt) && !irq_q;
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 4'd0;
      tmo_q      <= 21'd0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      ack_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tmo_q      <= tmo_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      ack_q      <= ack_d;
      irq_q      <= irq_d;
    end
  end

  // Byte storage; contents need no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ctrl_tx_data;
  end

endmodule

// File: tb/tb_tx_fifo.sv
// Scoreboard bench for tx_fifo: bytes are queued as they are pushed and
// compared when tx_start presents them; a transmitter stand-in returns tx_finish.
module tb_tx_fifo;

  localparam logic [20:0] TMO = 21'd40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ctrl_tx_data = 8'h00;
  logic       ctrl_tx_valid = 1'b0;
  logic       tx_busy = 1'b0;
  logic       tx_finish = 1'b0;
  logic       tx_ctrl_ack;
  logic       tx_ctrl_full;
  logic [3:0] fifo_count;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       fifo_interrupt;

  tx_fifo #(.DEPTH(8), .THRESH(2), .TIMEOUT(TMO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ctrl_tx_data   (ctrl_tx_data),
    .ctrl_tx_valid  (ctrl_tx_valid),
    .tx_ctrl_ack    (tx_ctrl_ack),
    .tx_ctrl_full   (tx_ctrl_full),
    .fifo_count     (fifo_count),
    .tx_start       (tx_start),
    .tx_data        (tx_data),
    .tx_busy        (tx_busy),
    .tx_finish      (tx_finish),
    .fifo_interrupt (fifo_interrupt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  int         start_cyc[$];
  int         irq_cyc[$];
  int         ack_cnt = 0;
  int         max_count = 0;
  bit         auto_fin = 1'b0;
  int         fin_delay = 1;
  logic       prev_start = 1'b0;
  logic       prev_irq = 1'b0;
  logic [7:0] exp_b;

  // Output monitor: scoreboard compare on launch, pulse-width rules
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_start) begin
        start_cyc.push_back(cyc);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL launch_data: got %02h with no byte expected", tx_data);
        end else begin
          exp_b = sb.pop_front();
          if (tx_data !== exp_b) begin
            errors++;
            $display("FAIL launch_data: got %02h expected %02h", tx_data, exp_b);
          end
        end
        checks++;
        if (prev_start) begin
          errors++;
          $display("FAIL start_pulse: tx_start high 2 cycles, expected 1");
        end
      end
      if (fifo_interrupt) begin
        irq_cyc.push_back(cyc);
        checks++;
        if (prev_irq) begin
          errors++;
          $display("FAIL irq_pulse: interrupt high 2 cycles, expected 1");
        end
      end
      if (tx_ctrl_ack) ack_cnt++;
      if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
      prev_start = tx_start;
      prev_irq   = fifo_interrupt;
    end else begin
      prev_start = 1'b0;
      prev_irq   = 1'b0;
    end
  end

  // Transmitter stand-in: finish pulse fin_delay cycles into WAIT
  always begin
    @(negedge clk);
    if (tx_start === 1'b1 && auto_fin && rst_n) begin
      repeat (fin_delay) @(posedge clk);
      #1 tx_finish = 1'b1;
      @(posedge clk);
      #1 tx_finish = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [7:0] b, input bit accept);
    ctrl_tx_valid = 1'b1;
    ctrl_tx_data  = b;
    if (accept) sb.push_back(b);
    tick(1);
  endtask

  task automatic wait_drain(input int bound, input string name);
    int n = 0;
    while ((sb.size() != 0 || fifo_count != 4'd0) && n < bound) begin
      tick(1);
      n++;
    end
    checks++;
    if (n >= bound) begin
      errors++;
      $display("FAIL %s_drain: %0d bytes pending, expected 0", name, sb.size());
    end
    tick(fin_delay + 6);
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (tx_start !== 1'b0 || tx_data !== 8'h00 || tx_ctrl_ack !== 1'b0 ||
        fifo_interrupt !== 1'b0 || fifo_count !== 4'd0 || tx_ctrl_full !== 1'b0) begin
      errors++;
      $display("FAIL %s: start=%b data=%02h ack=%b irq=%b count=%0d full=%b, expected 0 00 0 0 0 0",
               name, tx_start, tx_data, tx_ctrl_ack, fifo_interrupt, fifo_count, tx_ctrl_full);
    end
  endtask

  task automatic test_reset();
    #12;
    check_reset_outputs("reset_values");
    @(negedge clk);
    auto_fin  = 1'b1;
    fin_delay = 1;
    rst_n     = 1'b1;
    ctrl_tx_valid = 1'b1;
    ctrl_tx_data  = 8'h3C;
    sb.push_back(8'h3C);
    @(posedge clk);
    #1 ctrl_tx_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_ctrl_ack !== 1'b1 || fifo_count !== 4'd1) begin
      errors++;
      $display("FAIL first_push: ack=%b count=%0d, expected 1 1", tx_ctrl_ack, fifo_count);
    end
    wait_drain(50, "first_push");
  endtask

  task automatic test_single();
    int c0;
    tick(1);
    start_cyc.delete();
    c0 = cyc;
    push_one(8'hA5, 1'b1);
    ctrl_tx_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_ctrl_ack !== 1'b1) begin
      errors++;
      $display("FAIL single_ack: got %b expected 1", tx_ctrl_ack);
    end
    @(negedge clk);
    checks++;
    if (tx_ctrl_ack !== 1'b0) begin
      errors++;
      $display("FAIL single_ack_low: got %b expected 0", tx_ctrl_ack);
    end
    wait_drain(50, "single");
    checks++;
    if (start_cyc.size() != 1 || start_cyc[0] != c0 + 3) begin
      errors++;
      $display("FAIL single_latency: %0d starts, first at +%0d, expected 1 at +3",
               start_cyc.size(), (start_cyc.size() > 0) ? start_cyc[0] - c0 : -1);
    end
    checks++;
    if (tx_data !== 8'hA5 || fifo_count !== 4'd0) begin
      errors++;
      $display("FAIL single_hold: data=%02h count=%0d, expected a5 0", tx_data, fifo_count);
    end
  endtask

  task automatic test_full();
    int a0;
    tx_busy   = 1'b1;
    fin_delay = 2;
    start_cyc.delete();
    a0 = ack_cnt;
    for (int i = 1; i <= 9; i++) push_one(8'(i), i <= 8);
    ctrl_tx_valid = 1'b0;
    tick(2);
    @(negedge clk);
    checks++;
    if (ack_cnt - a0 != 8 || tx_ctrl_full !== 1'b1 || fifo_count !== 4'd8) begin
      errors++;
      $display("FAIL full_fill: acks=%0d full=%b count=%0d, expected 8 1 8",
               ack_cnt - a0, tx_ctrl_full, fifo_count);
    end
    tx_busy = 1'b0;
    wait_drain(400, "full");
    checks++;
    if (start_cyc.size() != 8) begin
      errors++;
      $display("FAIL full_launches: got %0d expected 8", start_cyc.size());
    end
  endtask

  task automatic test_refill();
    tx_busy   = 1'b1;
    fin_delay = 10;
    start_cyc.delete();
    irq_cyc.delete();
    push_one(8'hAA, 1'b1);
    push_one(8'hBB, 1'b1);
    push_one(8'hCC, 1'b1);
    push_one(8'hDD, 1'b1);
    ctrl_tx_valid = 1'b0;
    tx_busy = 1'b0;
    wait_drain(300, "refill");
    checks++;
    if (irq_cyc.size() != 2 || start_cyc.size() != 4) begin
      errors++;
      $display("FAIL refill_count: irqs=%0d starts=%0d, expected 2 4", irq_cyc.size(), start_cyc.size());
    end else begin
      checks++;
      if (irq_cyc[0] != start_cyc[1]) begin
        errors++;
        $display("FAIL refill_timing: irq at %0d expected %0d", irq_cyc[0], start_cyc[1]);
      end
      checks++;
      if (irq_cyc[1] != start_cyc[3] + 11) begin
        errors++;
        $display("FAIL done_timing: irq at %0d expected %0d", irq_cyc[1], start_cyc[3] + 11);
      end
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    auto_fin = 1'b0;
    tx_busy  = 1'b1;
    start_cyc.delete();
    irq_cyc.delete();
    push_one(8'h51, 1'b1);
    push_one(8'h52, 1'b1);
    ctrl_tx_valid = 1'b0;
    tx_busy = 1'b0;
    while (irq_cyc.size() == 0 && n < int'(TMO) + 20) begin
      tick(1);
      n++;
    end
    auto_fin  = 1'b1;
    fin_delay = 1;
    checks++;
    if (irq_cyc.size() == 0 || start_cyc.size() == 0) begin
      errors++;
      $display("FAIL timeout_irq: irqs=%0d starts=%0d, expected 1 1", irq_cyc.size(), start_cyc.size());
    end else begin
      checks++;
      if (irq_cyc[0] - start_cyc[0] != int'(TMO)) begin
        errors++;
        $display("FAIL timeout_len: got %0d cycles expected %0d", irq_cyc[0] - start_cyc[0], TMO);
      end
    end
    wait_drain(100, "timeout");
    checks++;
    if (start_cyc.size() != 2 || irq_cyc.size() != 2) begin
      errors++;
      $display("FAIL timeout_next: starts=%0d irqs=%0d, expected 2 2", start_cyc.size(), irq_cyc.size());
    end else begin
      checks++;
      if (start_cyc[1] != irq_cyc[0] + 2) begin
        errors++;
        $display("FAIL timeout_relaunch: start at %0d expected %0d", start_cyc[1], irq_cyc[0] + 2);
      end
    end
  endtask

  task automatic test_reset_wait();
    int n = 0;
    int s0;
    int i0;
    auto_fin = 1'b0;
    tx_busy  = 1'b1;
    start_cyc.delete();
    push_one(8'h61, 1'b1);
    push_one(8'h62, 1'b1);
    push_one(8'h63, 1'b1);
    ctrl_tx_valid = 1'b0;
    tx_busy = 1'b0;
    while (start_cyc.size() == 0 && n < 20) begin
      tick(1);
      n++;
    end
    checks++;
    if (start_cyc.size() == 0) begin
      errors++;
      $display("FAIL rstwait_launch: got 0 launches expected 1");
    end
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("rstwait_async");
    sb.delete();
    s0 = start_cyc.size();
    i0 = irq_cyc.size();
    tick(2);
    rst_n = 1'b1;
    tick(30);
    checks++;
    if (start_cyc.size() != s0 || irq_cyc.size() != i0 || fifo_count !== 4'd0) begin
      errors++;
      $display("FAIL rstwait_quiet: starts=%0d irqs=%0d count=%0d, expected %0d %0d 0",
               start_cyc.size(), irq_cyc.size(), fifo_count, s0, i0);
    end
  endtask

  task automatic test_wrap();
    int a0;
    auto_fin  = 1'b1;
    fin_delay = 1;
    tx_busy   = 1'b0;
    start_cyc.delete();
    a0 = ack_cnt;
    max_count = 0;
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 4; k++) push_one(8'(8'h80 + b * 4 + k), 1'b1);
      ctrl_tx_valid = 1'b0;
      tick(16);
    end
    wait_drain(300, "wrap");
    checks++;
    if (ack_cnt - a0 != 20 || start_cyc.size() != 20) begin
      errors++;
      $display("FAIL wrap_totals: acks=%0d starts=%0d, expected 20 20", ack_cnt - a0, start_cyc.size());
    end
    checks++;
    if (max_count > 8 || max_count < 2) begin
      errors++;
      $display("FAIL wrap_occupancy: max=%0d expected 2..8", max_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_refill();
    test_timeout();
    test_reset_wait();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
